// File: rtl/io_bridge.sv
// Wishbone I/O bridge: decodes a 4-bit slot field and runs one single-beat access per request.
// Slot 0 is an internal edge-latching interrupt controller. Define IO_BRIDGE_TIMEOUT_EN for the stalled-slave timeout.

module io_bridge #(
    parameter int          NSLOTS  = 16,
    parameter int          SELLSB  = 12,
    parameter int          ADRW    = 17,
    parameter logic [15:0] MAP     = 16'hFFFF,
    parameter int          TIMEOUT = 255,
    parameter int          NIRQ    = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cyc_i,
    input  logic                   stb_i,
    input  logic                   we_i,
    input  logic [ADRW-1:0]        adr_i,
    input  logic [31:0]            dat_i,
    input  logic [3:0]             sel_i,
    output logic [31:0]            dat_o,
    output logic                   ack_o,
    output logic                   err_o,
    output logic                   s_cyc_o,
    output logic [NSLOTS-1:0]      s_stb_o,
    output logic                   s_we_o,
    output logic [ADRW-1:0]        s_adr_o,
    output logic [31:0]            s_dat_o,
    output logic [3:0]             s_sel_o,
    input  logic [NSLOTS*32-1:0]   s_dat_i,
    input  logic [NSLOTS-1:0]      s_ack_i,
    input  logic [NIRQ-1:0]        irq_i,
    output logic                   irq_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

    state_t            state_q, state_d;
    logic [3:0]        slot_q;
    logic              we_q;
    logic [ADRW-1:0]   adr_q;
    logic [31:0]       wdat_q;
    logic [3:0]        sel_q;
    logic [NIRQ-1:0]   irq_q, pending_q, mask_q, w1c;

    logic              slot_int, slot_ext, sel_ack, tmo_hit;
    logic [31:0]       sel_rdata, int_rdata;
    logic              accept, int_commit, ext_done, err_unmapped, err_tmo;

    assign slot_int = (slot_q == 4'd0);
    assign slot_ext = !slot_int && ({28'd0, slot_q} < NSLOTS[31:0]) && MAP[slot_q];

    assign s_cyc_o = (state_q == BUSY) && slot_ext;
    assign s_we_o  = we_q;
    assign s_adr_o = adr_q;
    assign s_dat_o = wdat_q;
    assign s_sel_o = sel_q;

    // Only the addressed slave's strobe, ack and data slice participate.
    always_comb begin
        s_stb_o   = '0;
        sel_rdata = '0;
        sel_ack   = 1'b0;
        for (int i = 0; i < NSLOTS; i++) begin
            s_stb_o[i] = s_cyc_o && (slot_q == 4'(i));
            if (slot_q == 4'(i)) begin
                sel_rdata = s_dat_i[32*i +: 32];
                sel_ack   = s_ack_i[i];
            end
        end
    end

    always_comb begin
        int_rdata = '0;
        case (adr_q[3:2])
            2'd0:    int_rdata[NIRQ-1:0] = pending_q;
            2'd1:    int_rdata[NIRQ-1:0] = mask_q;
            2'd2:    int_rdata[NIRQ-1:0] = irq_i;
            default: int_rdata = '0;
        endcase
    end

`ifdef IO_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] tmo_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            tmo_cnt <= '0;
        else if (state_q == IDLE)
            tmo_cnt <= '0;
        else if (state_q == BUSY && slot_ext && !sel_ack)
            tmo_cnt <= tmo_cnt + 16'd1;
    end

    assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Dropping cyc_i mid-access beats every other BUSY outcome, including internal commits.
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        int_commit   = 1'b0;
        ext_done     = 1'b0;
        err_unmapped = 1'b0;
        err_tmo      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cyc_i && stb_i) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!cyc_i) begin
                    state_d = IDLE;
                end else if (slot_int) begin
                    int_commit = 1'b1;
                    state_d    = DONE;
                end else if (!slot_ext) begin
                    err_unmapped = 1'b1;
                    state_d      = ERR;
                end else if (sel_ack) begin
                    ext_done = 1'b1;
                    state_d  = DONE;
                end else if (tmo_hit) begin
                    err_tmo = 1'b1;
                    state_d = ERR;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign w1c = (int_commit && we_q && adr_q[3:2] == 2'd0) ? wdat_q[NIRQ-1:0] : '0;

    // A rising edge in the same cycle as a W1C of that bit keeps the bit set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dat_o     <= '0;
            ack_o     <= 1'b0;
            err_o     <= 1'b0;
            irq_o     <= 1'b0;
            slot_q    <= '0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            wdat_q    <= '0;
            sel_q     <= '0;
            irq_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            ack_o     <= (state_d == DONE);
            err_o     <= (state_d == ERR);
            irq_q     <= irq_i;
            pending_q <= (pending_q & ~w1c) | (irq_i & ~irq_q);
            irq_o     <= |(pending_q & mask_q);
            if (accept) begin
                slot_q <= adr_i[SELLSB+3:SELLSB];
                we_q   <= we_i;
                adr_q  <= adr_i;
                wdat_q <= dat_i;
                sel_q  <= sel_i;
            end
            if (int_commit && we_q && adr_q[3:2] == 2'd1)
                mask_q <= wdat_q[NIRQ-1:0];
            if (int_commit && !we_q)
                dat_o <= int_rdata;
            if (ext_done && !we_q)
                dat_o <= sel_rdata;
            if (err_unmapped)
                dat_o <= '0;
            if (err_tmo)
                dat_o <= 32'hDEADBEEF;
        end
    end

endmodule
